// File: rtl/pu_conn_context_lut.sv
// Shared connection-context lookup: PU {rci,ofs} -> indirection table -> context RAM at {sci,ofs}.
// Ack 4 cycles after the request edge when uncontended; a re-request on a still-pending lane is dropped with io_err.
module pu_conn_context_lut #(
   parameter int NUM_REQ     = 8,
   parameter int WIDTH_NBITS = 32,
   parameter int RCI_NBITS   = 8,
   parameter int SCI_NBITS   = 6,
   parameter int OFS_NBITS   = 4,
   parameter int ARB_MODE    = 0
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [NUM_REQ-1:0]                           io_req,
   input  logic [NUM_REQ-1:0]                           io_wr,
   input  logic [NUM_REQ-1:0][RCI_NBITS+OFS_NBITS-1:0]  io_addr,
   input  logic [NUM_REQ-1:0][WIDTH_NBITS-1:0]          io_wdata,
   output logic [NUM_REQ-1:0]                           io_ack,
   output logic [NUM_REQ-1:0][WIDTH_NBITS-1:0]          io_ack_data,
   output logic [NUM_REQ-1:0]                           io_err,
   input  logic                                         tbl_wr,
   input  logic [RCI_NBITS-1:0]                         tbl_waddr,
   input  logic [SCI_NBITS-1:0]                         tbl_wdata,
   output logic                                         busy
);
   localparam int ADDR_NBITS = RCI_NBITS + OFS_NBITS;
   localparam int LANE_NBITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int IDX_NBITS  = LANE_NBITS + 1;
   localparam int CTX_NBITS  = SCI_NBITS + OFS_NBITS;

   typedef struct packed {
      logic [LANE_NBITS-1:0]  lane;
      logic                   wr;
      logic [ADDR_NBITS-1:0]  addr;
      logic [WIDTH_NBITS-1:0] wdata;
   } op_t;

   logic [NUM_REQ-1:0]                  pending;
   logic [NUM_REQ-1:0]                  granted;
   logic [NUM_REQ-1:0]                  lane_wr;
   logic [NUM_REQ-1:0][ADDR_NBITS-1:0]  lane_addr;
   logic [NUM_REQ-1:0][WIDTH_NBITS-1:0] lane_wdata;
   logic [LANE_NBITS-1:0]               rr_ptr;

   logic [NUM_REQ-1:0]    cand;
   logic                  gnt_vld;
   logic [LANE_NBITS-1:0] gnt_idx;
   logic [IDX_NBITS-1:0]  arb_idx;
   logic [NUM_REQ-1:0]    ack_clr;

   logic                   s1_vld;
   op_t                    s1_op;
   logic                   s2_vld;
   logic [LANE_NBITS-1:0]  s2_lane;
   logic                   s2_wr;
   logic [OFS_NBITS-1:0]   s2_ofs;
   logic [WIDTH_NBITS-1:0] s2_wdata;
   logic [SCI_NBITS-1:0]   s2_sci;
   logic                   s3_vld;
   logic [LANE_NBITS-1:0]  s3_lane;
   logic                   s3_wr;

   logic [SCI_NBITS-1:0]   tbl_mem [2**RCI_NBITS];
   logic                   tbl_wr_q;
   logic [RCI_NBITS-1:0]   tbl_waddr_q;
   logic [SCI_NBITS-1:0]   tbl_wdata_q;
   logic [SCI_NBITS-1:0]   tbl_rd_q;
   logic                   byp_hit;
   logic [SCI_NBITS-1:0]   byp_sci;
   logic [RCI_NBITS-1:0]   s1_rci;

   logic [WIDTH_NBITS-1:0] ctx_mem [2**CTX_NBITS];
   logic [CTX_NBITS-1:0]   ctx_addr;
   logic [WIDTH_NBITS-1:0] ctx_rd_q;

   assign cand   = pending & ~granted;
   assign s1_rci = s1_op.addr[ADDR_NBITS-1:OFS_NBITS];
   assign s2_sci = byp_hit ? byp_sci : tbl_rd_q;
   assign ctx_addr = {s2_sci, s2_ofs};
   assign busy   = (|pending) | s1_vld | s2_vld | s3_vld;

   // Scan from the RR pointer (or from lane 0 in fixed mode), first candidate wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      arb_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_idx = (ARB_MODE == 0) ? ({1'b0, rr_ptr} + IDX_NBITS'(k)) : IDX_NBITS'(k);
         if (arb_idx >= IDX_NBITS'(NUM_REQ))
            arb_idx = arb_idx - IDX_NBITS'(NUM_REQ);
         if (!gnt_vld && cand[arb_idx[LANE_NBITS-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = arb_idx[LANE_NBITS-1:0];
         end
      end
   end

   always_comb begin
      ack_clr = '0;
      if (s3_vld)
         ack_clr[s3_lane] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending    <= '0;
         granted    <= '0;
         lane_wr    <= '0;
         lane_addr  <= '0;
         lane_wdata <= '0;
         io_err     <= '0;
      end else begin
         io_err <= io_req & pending;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (ack_clr[i]) begin
               pending[i] <= 1'b0;
               granted[i] <= 1'b0;
            end else if (io_req[i] && !pending[i]) begin
               pending[i]    <= 1'b1;
               lane_wr[i]    <= io_wr[i];
               lane_addr[i]  <= io_addr[i];
               lane_wdata[i] <= io_wdata[i];
            end
            if (gnt_vld && gnt_idx == LANE_NBITS'(i))
               granted[i] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr      <= '0;
         s1_vld      <= 1'b0;
         s1_op       <= '0;
         s2_vld      <= 1'b0;
         s2_lane     <= '0;
         s2_wr       <= 1'b0;
         s2_ofs      <= '0;
         s2_wdata    <= '0;
         s3_vld      <= 1'b0;
         s3_lane     <= '0;
         s3_wr       <= 1'b0;
         tbl_wr_q    <= 1'b0;
         tbl_waddr_q <= '0;
         tbl_wdata_q <= '0;
         byp_hit     <= 1'b0;
         byp_sci     <= '0;
         io_ack      <= '0;
         io_ack_data <= '0;
      end else begin
         s1_vld <= gnt_vld;
         if (gnt_vld) begin
            s1_op.lane  <= gnt_idx;
            s1_op.wr    <= lane_wr[gnt_idx];
            s1_op.addr  <= lane_addr[gnt_idx];
            s1_op.wdata <= lane_wdata[gnt_idx];
            rr_ptr      <= (gnt_idx == LANE_NBITS'(NUM_REQ - 1)) ? '0 : gnt_idx + LANE_NBITS'(1);
         end

         tbl_wr_q    <= tbl_wr;
         tbl_waddr_q <= tbl_waddr;
         tbl_wdata_q <= tbl_wdata;
         // The live write is newer than the registered one still landing in the table.
         byp_hit <= 1'b0;
         if (tbl_wr && tbl_waddr == s1_rci) begin
            byp_hit <= 1'b1;
            byp_sci <= tbl_wdata;
         end else if (tbl_wr_q && tbl_waddr_q == s1_rci) begin
            byp_hit <= 1'b1;
            byp_sci <= tbl_wdata_q;
         end

         s2_vld   <= s1_vld;
         s2_lane  <= s1_op.lane;
         s2_wr    <= s1_op.wr;
         s2_ofs   <= s1_op.addr[OFS_NBITS-1:0];
         s2_wdata <= s1_op.wdata;

         s3_vld  <= s2_vld;
         s3_lane <= s2_lane;
         s3_wr   <= s2_wr;

         io_ack      <= ack_clr;
         io_ack_data <= '0;
         if (s3_vld && !s3_wr)
            io_ack_data[s3_lane] <= ctx_rd_q;
      end
   end

   always_ff @(posedge clk) begin
      if (tbl_wr_q)
         tbl_mem[tbl_waddr_q] <= tbl_wdata_q;
      tbl_rd_q <= tbl_mem[s1_rci];
   end

   always_ff @(posedge clk) begin
      if (s2_vld && s2_wr)
         ctx_mem[ctx_addr] <= s2_wdata;
      ctx_rd_q <= ctx_mem[ctx_addr];
   end

endmodule

// File: tb/tb_pu_conn_context_lut.sv
// Bench for pu_conn_context_lut: directed scenarios plus a randomized multi-lane run against a table/RAM model.
module tb_pu_conn_context_lut;
   localparam int N  = 8;
   localparam int W  = 32;
   localparam int RB = 8;
   localparam int SB = 6;
   localparam int OB = 4;
   localparam int AB = RB + OB;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         io_req, io_wr, io_ack, io_err;
   logic [N-1:0][AB-1:0] io_addr;
   logic [N-1:0][W-1:0]  io_wdata, io_ack_data;
   logic                 tbl_wr;
   logic [RB-1:0]        tbl_waddr;
   logic [SB-1:0]        tbl_wdata;
   logic                 busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [SB-1:0] tbl_m [2**RB];
   logic [W-1:0]  ctx_m [2**(SB+OB)];

   always #5 clk = ~clk;

   pu_conn_context_lut #(
      .NUM_REQ(N), .WIDTH_NBITS(W), .RCI_NBITS(RB), .SCI_NBITS(SB), .OFS_NBITS(OB), .ARB_MODE(0)
   ) dut (
      .clk(clk), .rst(rst),
      .io_req(io_req), .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_ack(io_ack), .io_ack_data(io_ack_data), .io_err(io_err),
      .tbl_wr(tbl_wr), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
      .busy(busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int cidx(input int rci, input int ofs);
      return int'(tbl_m[rci]) * (2**OB) + ofs;
   endfunction

   task automatic tbl_set(input int rci, input int sci);
      tbl_wr    = 1'b1;
      tbl_waddr = RB'(rci);
      tbl_wdata = SB'(sci);
      tick;
      tbl_wr = 1'b0;
      tbl_m[rci] = SB'(sci);
   endtask

   task automatic drive_lane(input int lane, input bit wr, input int rci, input int ofs, input logic [W-1:0] wd);
      io_req[lane]   = 1'b1;
      io_wr[lane]    = wr;
      io_addr[lane]  = AB'(rci * (2**OB) + ofs);
      io_wdata[lane] = wd;
   endtask

   // Issues one op and waits (bounded) for its ack; lat counts edges after the sampling edge.
   task automatic run_op(input int lane, input bit wr, input int rci, input int ofs, input logic [W-1:0] wd,
                         output logic [W-1:0] rd, output logic [N-1:0] ack_vec, output int lat);
      io_req = '0;
      drive_lane(lane, wr, rci, ofs, wd);
      tick;
      io_req  = '0;
      lat     = -1;
      rd      = '0;
      ack_vec = '0;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         tick;
         if (io_ack[lane]) begin
            lat = c; rd = io_ack_data[lane]; ack_vec = io_ack;
         end
      end
      if (wr) ctx_m[cidx(rci, ofs)] = wd;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick;
      n_checks++; if (io_ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %h want 0", io_ack); end
      n_checks++; if (io_ack_data !== '0) begin n_fail++; $display("FAIL reset_ack_data: got %h want 0", io_ack_data); end
      n_checks++; if (io_err !== '0) begin n_fail++; $display("FAIL reset_err: got %h want 0", io_err); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_basic_read;
      logic [W-1:0] rd, exp;
      logic [N-1:0] av;
      int lat;
      tbl_set(5, 3);
      run_op(2, 1'b1, 5, 2, 32'hA5A5_0001, rd, av, lat);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL basic_wr_lat: got %0d want 4", lat); end
      n_checks++; if (rd !== '0) begin n_fail++; $display("FAIL basic_wr_data: got %h want 0", rd); end
      exp = ctx_m[cidx(5, 2)];
      run_op(0, 1'b0, 5, 2, '0, rd, av, lat);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL basic_rd_lat: got %0d want 4", lat); end
      n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL basic_rd_data: got %h want %h", rd, exp); end
      n_checks++; if (av !== N'(1)) begin n_fail++; $display("FAIL basic_rd_onehot: got %b want %b", av, N'(1)); end
   endtask

   task automatic test_rr_order;
      logic [W-1:0] rd, exp;
      logic [N-1:0] av, want;
      int lat, start, k;
      rst = 1'b1; tick; rst = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
         start = 0;
         if (pass == 1) begin
            run_op(2, 1'b0, 5, 2, '0, rd, av, lat);
            start = 3;
         end
         exp = ctx_m[cidx(5, 2)];
         for (int i = 0; i < N; i++) drive_lane(i, 1'b0, 5, 2, '0);
         tick;
         io_req = '0;
         for (int c = 1; c <= 14; c++) begin
            tick;
            k = c - 4;
            want = (k >= 0 && k < N) ? (N'(1) << ((start + k) % N)) : '0;
            n_checks++;
            if (io_ack !== want) begin n_fail++; $display("FAIL rr_order p%0d c%0d: got %b want %b", pass, c, io_ack, want); end
            if (k >= 0 && k < N) begin
               n_checks++;
               if (io_ack_data[(start + k) % N] !== exp) begin
                  n_fail++; $display("FAIL rr_data p%0d c%0d: got %h want %h", pass, c, io_ack_data[(start + k) % N], exp);
               end
            end
         end
      end
   endtask

   task automatic test_raw;
      logic [N-1:0] want;
      io_req = '0;
      drive_lane(2, 1'b1, 5, 2, 32'h0000_1234);
      tick;
      io_req = '0;
      drive_lane(1, 1'b0, 5, 2, '0);
      tick;
      io_req = '0;
      ctx_m[cidx(5, 2)] = 32'h0000_1234;
      for (int c = 1; c <= 8; c++) begin
         tick;
         want = (c == 3) ? N'(4) : (c == 4) ? N'(2) : '0;
         n_checks++;
         if (io_ack !== want) begin n_fail++; $display("FAIL raw_ack c%0d: got %b want %b", c, io_ack, want); end
         if (c == 3) begin
            n_checks++;
            if (io_ack_data[2] !== '0) begin n_fail++; $display("FAIL raw_wr_data: got %h want 0", io_ack_data[2]); end
         end
         if (c == 4) begin
            n_checks++;
            if (io_ack_data[1] !== ctx_m[cidx(5, 2)]) begin
               n_fail++; $display("FAIL raw_rd_data: got %h want %h", io_ack_data[1], ctx_m[cidx(5, 2)]);
            end
         end
      end
   endtask

   // d = cycle (after the request) in which tbl_wr for rci 5 is driven; d<=2 must reach this read.
   task automatic tbl_race(input int d, input int new_sci);
      logic [W-1:0] exp, got;
      int lat;
      exp = (d <= 2) ? ctx_m[new_sci * (2**OB) + 4] : ctx_m[cidx(5, 4)];
      io_req = '0;
      drive_lane(0, 1'b0, 5, 4, '0);
      lat = -1;
      got = '0;
      for (int c = 1; c <= 12; c++) begin
         tick;
         io_req    = '0;
         tbl_wr    = (c == d);
         tbl_waddr = RB'(5);
         tbl_wdata = SB'(new_sci);
         if (io_ack[0] && lat < 0) begin lat = c - 1; got = io_ack_data[0]; end
      end
      tbl_m[5] = SB'(new_sci);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL bypass_lat d%0d: got %0d want 4", d, lat); end
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL bypass_data d%0d: got %h want %h", d, got, exp); end
   endtask

   task automatic test_tbl_bypass;
      logic [W-1:0] rd, exp;
      logic [N-1:0] av;
      int lat;
      tbl_set(9, 7);
      run_op(3, 1'b1, 9, 4, 32'hCAFE_0007, rd, av, lat);
      run_op(3, 1'b1, 5, 4, 32'h3333_4444, rd, av, lat);
      tbl_race(2, 7);
      tbl_race(1, 3);
      tbl_race(3, 7);
      exp = ctx_m[cidx(5, 4)];
      run_op(0, 1'b0, 5, 4, '0, rd, av, lat);
      n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL bypass_after: got %h want %h", rd, exp); end
   endtask

   task automatic test_err;
      logic [W-1:0] exp;
      logic [N-1:0] want_ack, want_err;
      exp = ctx_m[cidx(9, 4)];
      io_req = '0;
      drive_lane(4, 1'b0, 9, 4, '0);
      for (int c = 1; c <= 14; c++) begin
         tick;
         io_req = '0;
         if (c == 2 || c == 5) drive_lane(4, 1'b0, 9, 4, '0);
         want_ack = (c == 5 || c == 10) ? N'(16) : '0;
         want_err = (c == 3) ? N'(16) : '0;
         n_checks++;
         if (io_ack !== want_ack) begin n_fail++; $display("FAIL err_ack c%0d: got %b want %b", c, io_ack, want_ack); end
         n_checks++;
         if (io_err !== want_err) begin n_fail++; $display("FAIL err_pulse c%0d: got %b want %b", c, io_err, want_err); end
         if (c == 5 || c == 10) begin
            n_checks++;
            if (io_ack_data[4] !== exp) begin n_fail++; $display("FAIL err_data c%0d: got %h want %h", c, io_ack_data[4], exp); end
         end
      end
   endtask

   task automatic test_reset_midflight;
      logic [W-1:0] rd, exp;
      logic [N-1:0] av, seen;
      int lat;
      io_req = '0;
      drive_lane(1, 1'b0, 9, 4, '0);
      drive_lane(3, 1'b0, 9, 4, '0);
      drive_lane(6, 1'b0, 9, 4, '0);
      tick;
      io_req = '0;
      tick;
      tick;
      rst = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_async: got %b want 0", busy); end
      tick;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
      rst = 1'b0;
      seen = '0;
      for (int c = 0; c < 12; c++) begin
         tick;
         seen |= io_ack;
      end
      n_checks++; if (seen !== '0) begin n_fail++; $display("FAIL midrst_no_ack: got %b want 0", seen); end
      exp = ctx_m[cidx(9, 4)];
      run_op(5, 1'b0, 9, 4, '0, rd, av, lat);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL midrst_fresh_lat: got %0d want 4", lat); end
      n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL midrst_fresh_data: got %h want %h", rd, exp); end
   endtask

   // Each lane owns rci 16+i -> sci 8+i, so per-lane ordering alone fixes every expected value.
   task automatic test_random;
      logic [2**OB-1:0] init_m [N];
      bit               outst  [N];
      int               issued [N];
      logic [W-1:0]     exp_d  [N];
      int               ofs, ci;
      bit               wr;
      logic [W-1:0]     wd;
      for (int i = 0; i < N; i++) begin
         tbl_set(16 + i, 8 + i);
         init_m[i] = '0; outst[i] = 1'b0; issued[i] = 0; exp_d[i] = '0;
      end
      io_req = '0;
      for (int cyc = 0; cyc < 420; cyc++) begin
         n_checks++;
         if ((io_ack & (io_ack - N'(1))) !== '0) begin n_fail++; $display("FAIL rand_onehot cyc%0d: got %b", cyc, io_ack); end
         n_checks++;
         if (io_err !== '0) begin n_fail++; $display("FAIL rand_err cyc%0d: got %b want 0", cyc, io_err); end
         for (int i = 0; i < N; i++) begin
            if (io_ack[i]) begin
               n_checks++;
               if (!outst[i]) begin n_fail++; $display("FAIL rand_spurious lane%0d cyc%0d: got ack want none", i, cyc); end
               n_checks++;
               if (io_ack_data[i] !== exp_d[i]) begin
                  n_fail++; $display("FAIL rand_data lane%0d cyc%0d: got %h want %h", i, cyc, io_ack_data[i], exp_d[i]);
               end
               n_checks++;
               if (cyc - issued[i] < 5 || cyc - issued[i] > N + 4) begin
                  n_fail++; $display("FAIL rand_latency lane%0d: got %0d want 5..%0d", i, cyc - issued[i], N + 4);
               end
               outst[i] = 1'b0;
            end
         end
         io_req = '0;
         if (cyc < 380) begin
            for (int i = 0; i < N; i++) begin
               if (!outst[i] && $urandom_range(2) == 0) begin
                  ofs = int'($urandom_range(2**OB - 1));
                  wr  = ($urandom_range(1) == 1) || !init_m[i][ofs];
                  wd  = $urandom;
                  ci  = (8 + i) * (2**OB) + ofs;
                  drive_lane(i, wr, 16 + i, ofs, wd);
                  if (wr) begin
                     ctx_m[ci] = wd; init_m[i][ofs] = 1'b1; exp_d[i] = '0;
                  end else begin
                     exp_d[i] = ctx_m[ci];
                  end
                  outst[i] = 1'b1;
                  issued[i] = cyc;
               end
            end
         end
         tick;
      end
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (outst[i]) begin n_fail++; $display("FAIL rand_drain lane%0d: got outstanding want acked", i); end
      end
   endtask

   initial begin
      rst       = 1'b1;
      io_req    = '0;
      io_wr     = '0;
      io_addr   = '0;
      io_wdata  = '0;
      tbl_wr    = 1'b0;
      tbl_waddr = '0;
      tbl_wdata = '0;
      test_reset;
      test_basic_read;
      test_rr_order;
      test_raw;
      test_tbl_bypass;
      test_err;
      test_reset_midflight;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pu_conn_context_lut.md
Name: pu_conn_context_lut

Overview:
- Shared connection-context lookup engine serving NUM_REQ processing units; the next-generation replacement for the single-mode, read-only context fetch path.
- Each PU issues a read or write addressed by {RCI, offset}. An internal RCI→SCI indirection table maps the RCI to a context slot. The context RAM is then accessed at {SCI, offset}, and the result is returned to the requesting PU.
- Sits between the PU io bus and the per-flow context storage. The indirection table is updated by the ASA side.

Parameters:
NUM_REQ, 8, number of requesting PUs (2..32)
WIDTH_NBITS, 32, context word width
RCI_NBITS, 8, RCI width (table depth 2^RCI_NBITS)
SCI_NBITS, 6, SCI width (table entry width)
OFS_NBITS, 4, word offset within one context slot
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
io_req  in  NUM_REQ  per-PU request strobe, one cycle per request
io_wr  in  NUM_REQ  1 = write, 0 = read (qualified by io_req)
io_addr  in  [RCI_NBITS+OFS_NBITS] x NUM_REQ  {rci, ofs}
io_wdata  in  [WIDTH_NBITS] x NUM_REQ  write data
io_ack  out  NUM_REQ  one-cycle completion pulse
io_ack_data  out  [WIDTH_NBITS] x NUM_REQ  read data; 0 for writes and non-acked lanes
io_err  out  NUM_REQ  one-cycle pulse: request dropped because lane busy
tbl_wr  in  1  indirection table write
tbl_waddr  in  RCI_NBITS  table index
tbl_wdata  in  SCI_NBITS  SCI value
busy  out  1  any lane pending or any pipeline stage valid

Behaviour:
- Reset: io_ack, io_ack_data, io_err, busy = 0. All pending flags, stage valids and the RR pointer are cleared (pointer = 0). RAM contents are not reset. Reset asserted mid-operation discards all in-flight requests with no ack.
- Per-lane capture: on io_req[i] with pending[i] = 0, latch wr/addr/wdata and set pending[i]. On io_req[i] with pending[i] = 1 and no ack this cycle, drop the request and pulse io_err[i] in the next cycle. A request in the same cycle as io_ack[i] is accepted, so a lane can sustain back-to-back requests.
- Arbitration (S0): one grant per cycle among lanes with pending = 1 that have not yet been granted.
  - ARB_MODE 0: search starts at the pointer; after each grant the pointer = granted index + 1, wrapping at NUM_REQ.
  - ARB_MODE 1: lowest index wins.
- Grant registers the lane id, wr, addr and wdata into S1.
- S1: table read at the latched rci (synchronous RAM). If tbl_wr hits the same index in the same cycle, S2 sees tbl_wdata (write-first bypass).
- tbl_wr is registered once before reaching the table. A bypass compare is also made against the registered write.
- S2: context RAM address = {sci, ofs}. Writes update the word; reads launch. The RAM is single-ported and takes one op per cycle in grant order, so read-after-write to the same slot returns the new data.
- S3: io_ack[lane] = 1 and io_ack_data[lane] = read data (0 for a write). pending[lane] clears on the same edge.
- Latency: io_req sampled at edge t gives io_ack high in the cycle after edge t+4 when uncontended. Throughput is one op per cycle aggregate.
- At most NUM_REQ ops are in flight, so no internal overflow is possible. At most one io_ack bit is set per cycle.
- Starvation bound in RR mode: a pending lane is granted within NUM_REQ cycles.

Test Plan:
- Table[5] = 3; ctx[{3,2}] = 0xA5A5_0001. Lane 0 reads {5,2} → io_ack[0] 4 cycles later, data 0xA5A5_0001, all other acks 0.
- All 8 lanes request in the same cycle, ARB_MODE 0 → acks on lanes 0..7 on 8 consecutive cycles. Repeat with the pointer at 3 → order 3..7, 0..2.
- Lane 2 writes {5,2} = 0x1234, then lane 1 reads {5,2} one cycle later → lane 1 gets 0x1234. Write ack data = 0.
- tbl_wr(5→7) in the same cycle lane 0's S1 read of rci 5 → access goes to SCI 7.
- Lane 4 re-requests while pending → io_err[4] pulse, exactly one io_ack[4]. A re-request in the ack cycle is accepted and acked 4 cycles later.
- Assert rst with 3 ops in flight → no acks, busy = 0 next cycle. A fresh request completes normally.
